// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core with internal instruction ROM, register file and data RAM.
// One instruction retires per rising clock edge; rst_n is an asynchronous active-high reset.

module rv32i_rom (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [7:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] ROM [0:255];

    // Load port is tied off in the core; programs normally arrive by hierarchical write.
    always_ff @(posedge clk) begin
        if (we) ROM[waddr] <= wdata;
    end

    assign rdata = ROM[raddr];
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] REGS [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) REGS[i] <= '0;
        end else if (we && wa != 5'd0) begin
            REGS[wa] <= wd;
        end
    end

    assign rdata1 = (ra1 == 5'd0) ? 32'd0 : REGS[ra1];
    assign rdata2 = (ra2 == 5'd0) ? 32'd0 : REGS[ra2];
endmodule

module rv32i_dmem (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  mask,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] RAM [0:255];

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) RAM[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = RAM[addr];
endmodule

module rv32i_cpu (
    input logic clk,
    input logic rst_n
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc, pc_next, instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rd1, rd2, rf_wd, mem_addr, mem_rdata, mem_wdata, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  mem_mask;
    logic        rf_we, mem_we, taken;
    logic        unused_bits;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    rv32i_rom I_mem (
        .clk   (clk),
        .we    (1'b0),
        .waddr (8'd0),
        .wdata (32'd0),
        .raddr (pc[9:2]),
        .rdata (instr)
    );

    rv32i_regfile RF (
        .clk    (clk),
        .rst    (rst_n),
        .ra1    (rs1),
        .ra2    (rs2),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .we     (rf_we),
        .wa     (rd),
        .wd     (rf_wd)
    );

    rv32i_dmem D_mem (
        .clk   (clk),
        .rst   (rst_n),
        .we    (mem_we),
        .mask  (mem_mask),
        .addr  (mem_addr[9:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign mem_addr    = rd1 + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign unused_bits = ^mem_addr[31:10];

    // Lane extraction for loads; only addr[1:0] picks the lane, misalignment is ignored.
    always_comb begin
        case (mem_addr[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = (rd1 == rd2);
            3'b001:  taken = (rd1 != rd2);
            3'b100:  taken = ($signed(rd1) <  $signed(rd2));
            3'b101:  taken = ($signed(rd1) >= $signed(rd2));
            3'b110:  taken = (rd1 <  rd2);
            3'b111:  taken = (rd1 >= rd2);
            default: taken = 1'b0;
        endcase
    end

    // Decode/execute; anything not matched below falls through as a NOP.
    always_comb begin
        rf_we     = 1'b0;
        rf_wd     = '0;
        mem_we    = 1'b0;
        mem_mask  = '0;
        mem_wdata = '0;
        pc_next   = pc + 32'd4;
        case (opcode)
            OP_LUI: begin
                rf_we = 1'b1;
                rf_wd = imm_u;
            end
            OP_AUIPC: begin
                rf_we = 1'b1;
                rf_wd = pc + imm_u;
            end
            OP_JAL: begin
                rf_we   = 1'b1;
                rf_wd   = pc + 32'd4;
                pc_next = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we   = 1'b1;
                    rf_wd   = pc + 32'd4;
                    pc_next = (rd1 + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                if (taken) pc_next = pc + imm_b;
            end
            OP_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
                    rf_we = 1'b1;
                    rf_wd = load_val;
                end
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin
                        mem_we    = 1'b1;
                        mem_mask  = 4'b0001 << mem_addr[1:0];
                        mem_wdata = {4{rd2[7:0]}};
                    end
                    3'b001: begin
                        mem_we    = 1'b1;
                        mem_mask  = mem_addr[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{rd2[15:0]}};
                    end
                    3'b010: begin
                        mem_we    = 1'b1;
                        mem_mask  = 4'b1111;
                        mem_wdata = rd2;
                    end
                    default: ;
                endcase
            end
            OP_IMM: begin
                if ((funct3 == 3'b001 && funct7 == 7'd0) ||
                    (funct3 == 3'b101 && (funct7 == 7'd0 || funct7 == 7'b0100000)) ||
                    (funct3 != 3'b001 && funct3 != 3'b101)) begin
                    rf_we = 1'b1;
                    rf_wd = alu(funct3, funct3 == 3'b101 && instr[30], rd1, imm_i);
                end
            end
            OP_REG: begin
                if (funct7 == 7'd0 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    rf_we = 1'b1;
                    rf_wd = alu(funct3, instr[30], rd1, rd2);
                end
            end
            default: ;
        endcase
    end

    // PC lives in a 1 KiB space; every next-PC wraps there.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) pc <= '0;
        else       pc <= pc_next & 32'h0000_03FF;
    end
endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed-program bench for rv32i_cpu: an instruction-level model runs in lockstep
// and every register plus the PC is compared each cycle, alongside literal results.

module tb_rv32i_cpu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] prog  [0:255];
    logic [31:0] m_rom [0:255];
    logic [31:0] m_ram [0:255];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;

    rv32i_cpu dut (.clk(clk), .rst_n(rst_n));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---- instruction encoders ----
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] v, a, f, d;
        v = imm; a = rs1; f = f3; d = rd;
        return {v[11:0], a[4:0], f[2:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v, d;
        v = imm20; d = rd;
        return {v[19:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
    endfunction

    // ---- ISA-level model ----
    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, ii, is, ib, ij, ea, w, res, nx;
        int op, f3, rd, sh;
        bit wr;
        ins = m_rom[m_pc[9:2]];
        op  = int'(ins[6:0]);
        rd  = int'(ins[11:7]);
        f3  = int'(ins[14:12]);
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        ii  = $unsigned($signed(ins) >>> 20);
        is  = ($unsigned($signed(ins) >>> 25) << 5) | {27'd0, ins[11:7]};
        ib  = ($unsigned($signed(ins) >>> 31) << 12) | {20'd0, ins[7], ins[30:25], ins[11:8], 1'b0};
        ij  = ($unsigned($signed(ins) >>> 31) << 20) | {12'd0, ins[19:12], ins[20], ins[30:21], 1'b0};
        nx  = m_pc + 4;
        wr  = 1'b0;
        res = 32'd0;
        case (op)
            'h37: begin wr = 1; res = {ins[31:12], 12'd0}; end
            'h17: begin wr = 1; res = m_pc + {ins[31:12], 12'd0}; end
            'h6F: begin wr = 1; res = m_pc + 4; nx = m_pc + ij; end
            'h67: begin wr = 1; res = m_pc + 4; nx = (a + ii) & 32'hFFFF_FFFE; end
            'h63: begin
                case (f3)
                    0: if (a == b) nx = m_pc + ib;
                    1: if (a != b) nx = m_pc + ib;
                    4: if ($signed(a) <  $signed(b)) nx = m_pc + ib;
                    5: if ($signed(a) >= $signed(b)) nx = m_pc + ib;
                    6: if (a <  b) nx = m_pc + ib;
                    7: if (a >= b) nx = m_pc + ib;
                    default: ;
                endcase
            end
            'h03: begin
                ea = a + ii;
                w  = m_ram[ea[9:2]];
                sh = 8 * int'(ea[1:0]);
                wr = 1;
                case (f3)
                    0: res = $unsigned(32'($signed(8'(w >> sh))));
                    1: res = $unsigned(32'($signed(16'(w >> (ea[1] ? 16 : 0)))));
                    4: res = (w >> sh) & 32'hFF;
                    5: res = (w >> (ea[1] ? 16 : 0)) & 32'hFFFF;
                    default: res = w;
                endcase
            end
            'h23: begin
                ea = a + is;
                w  = m_ram[ea[9:2]];
                if (f3 == 0) begin
                    sh = 8 * int'(ea[1:0]);
                    w = (w & ~(32'hFF << sh)) | ((b & 32'hFF) << sh);
                end else if (f3 == 1) begin
                    sh = ea[1] ? 16 : 0;
                    w = (w & ~(32'hFFFF << sh)) | ((b & 32'hFFFF) << sh);
                end else begin
                    w = b;
                end
                m_ram[ea[9:2]] = w;
            end
            'h13, 'h33: begin
                logic [31:0] o;
                o  = (op == 'h13) ? ii : b;
                wr = 1;
                case (f3)
                    0: res = (op == 'h33 && ins[30]) ? a - o : a + o;
                    1: res = a << o[4:0];
                    2: res = ($signed(a) < $signed(o)) ? 32'd1 : 32'd0;
                    3: res = (a < o) ? 32'd1 : 32'd0;
                    4: res = a ^ o;
                    5: res = ins[30] ? $unsigned($signed(a) >>> o[4:0]) : a >> o[4:0];
                    6: res = a | o;
                    default: res = a & o;
                endcase
            end
            default: ;
        endcase
        if (wr && rd != 0) m_regs[rd] = res;
        m_pc = nx & 32'h3FF;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_step();
    end

    // Lockstep compare of architectural state, away from the active edge.
    always @(negedge clk) begin
        chk("pc", dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            chk($sformatf("x%0d", i), dut.RF.REGS[i], m_regs[i]);
    end

    // ---- helpers ----
    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) begin
            dut.I_mem.ROM[i] <= prog[i];
            dut.D_mem.RAM[i] <= 32'd0;
            m_rom[i] = prog[i];
            m_ram[i] = 32'd0;
        end
        #1;
    endtask

    task automatic start_prog();
        rst_n = 1'b1;
        model_reset();
        load_prog();
        @(negedge clk);
        #1 rst_n = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int r, input logic [31:0] exp);
        chk(nm, dut.RF.REGS[r], exp);
        chk({nm, "_model"}, m_regs[r], exp);
    endtask

    task automatic lit_pc(input string nm, input logic [31:0] exp);
        chk(nm, dut.pc, exp);
        chk({nm, "_model"}, m_pc, exp);
    endtask

    initial begin
        // Countdown loop: 30 ns reset, 64 cycles to first loop-back.
        clear_prog();
        prog[0] = 32'h01400093; prog[1] = 32'h00100113; prog[2] = 32'h402080B3;
        prog[3] = 32'h00118193; prog[4] = 32'hFE104CE3; prog[5] = 32'hFED18193;
        prog[6] = 32'hFE9FF06F;
        #1 rst_n = 1'b1;
        model_reset();
        load_prog();
        lit_pc("rst_pc", 32'd0);
        lit("rst_x1", 1, 32'd0);
        #(30 - $time) rst_n = 1'b0;
        run(64);
        lit("cd_x1", 1, 32'd0);
        lit("cd_x2", 2, 32'd1);
        lit("cd_x3", 3, 32'd1);
        lit_pc("cd_pc", 32'd0);
        run(1);
        lit("cd_x1_again", 1, 32'd20);

        // Mid-program reset: clears asynchronously, restarts at ROM[0].
        run(10);
        #2 rst_n = 1'b1;
        model_reset();
        #1;
        chk("async_pc", dut.pc, 32'd0);
        chk("async_x1", dut.RF.REGS[1], 32'd0);
        chk("async_x2", dut.RF.REGS[2], 32'd0);
        chk("async_x3", dut.RF.REGS[3], 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        run(1);
        lit("restart_x1", 1, 32'd20);
        lit_pc("restart_pc", 32'd4);

        // ALU sweep.
        clear_prog();
        prog[0]  = enc_i(-1, 0, 0, 5, 7'h13);
        prog[1]  = enc_i(28, 5, 5, 6, 7'h13);
        prog[2]  = enc_i(32'h400 | 28, 5, 5, 7, 7'h13);
        prog[3]  = enc_r(0, 5, 0, 3, 8);
        prog[4]  = enc_u(32'h12345, 9, 7'h37);
        prog[5]  = enc_u(1, 10, 7'h17);
        prog[6]  = enc_r(0, 6, 5, 0, 11);
        prog[7]  = enc_r(32, 5, 6, 0, 12);
        prog[8]  = enc_r(0, 5, 9, 4, 13);
        prog[9]  = enc_r(0, 9, 6, 6, 14);
        prog[10] = enc_r(0, 9, 7, 7, 15);
        prog[11] = enc_r(0, 6, 6, 1, 16);
        prog[12] = enc_r(0, 0, 5, 2, 17);
        prog[13] = enc_i(-1, 6, 2, 18, 7'h13);
        prog[14] = enc_i(-1, 6, 3, 19, 7'h13);
        prog[15] = enc_i(32'h555, 5, 4, 20, 7'h13);
        prog[16] = enc_i(-2048, 0, 6, 21, 7'h13);
        prog[17] = enc_i(32'h7FF, 10, 7, 22, 7'h13);
        prog[18] = enc_i(31, 6, 1, 23, 7'h13);
        prog[19] = enc_r(0, 6, 5, 5, 24);
        prog[20] = enc_r(32, 6, 23, 5, 25);
        start_prog();
        run(21);
        lit("srli", 6, 32'h0000000F);
        lit("srai", 7, 32'hFFFFFFFF);
        lit("sltu", 8, 32'd1);
        lit("lui", 9, 32'h12345000);
        lit("auipc", 10, 32'h00001014);
        lit("add", 11, 32'h0000000E);
        lit("sub", 12, 32'h00000010);
        lit("xor", 13, 32'hEDCBAFFF);
        lit("or", 14, 32'h1234500F);
        lit("and", 15, 32'h12345000);
        lit("sll", 16, 32'h00078000);
        lit("slt", 17, 32'd1);
        lit("slti", 18, 32'd0);
        lit("sltiu", 19, 32'd1);
        lit("xori", 20, 32'hFFFFFAAA);
        lit("ori", 21, 32'hFFFFF800);
        lit("andi", 22, 32'h00000014);
        lit("slli", 23, 32'h80000000);
        lit("srl", 24, 32'h0001FFFF);
        lit("sra", 25, 32'hFFFF0000);

        // Memory: sub-word loads/stores with sign/zero extension.
        clear_prog();
        prog[0]  = enc_i(32'h80, 0, 0, 1, 7'h13);
        prog[1]  = enc_u(32'h80010, 2, 7'h37);
        prog[2]  = enc_i(-129, 2, 0, 2, 7'h13);
        prog[3]  = enc_s(0, 2, 1, 2);
        prog[4]  = enc_i(0, 1, 0, 3, 7'h03);
        prog[5]  = enc_i(0, 1, 4, 4, 7'h03);
        prog[6]  = enc_i(2, 1, 1, 5, 7'h03);
        prog[7]  = enc_i(2, 1, 5, 6, 7'h03);
        prog[8]  = enc_s(1, 0, 1, 0);
        prog[9]  = enc_i(0, 1, 2, 7, 7'h03);
        prog[10] = enc_s(6, 2, 1, 1);
        prog[11] = enc_i(4, 1, 2, 8, 7'h03);
        prog[12] = enc_i(3, 1, 0, 9, 7'h03);
        start_prog();
        run(14);
        lit("sw_val", 2, 32'h8000FF7F);
        lit("lb", 3, 32'h0000007F);
        lit("lbu", 4, 32'h0000007F);
        lit("lh", 5, 32'hFFFF8000);
        lit("lhu", 6, 32'h00008000);
        lit("lw_after_sb", 7, 32'h8000007F);
        lit("lw_after_sh", 8, 32'hFF7F0000);
        lit("lb_byte3", 9, 32'hFFFFFF80);
        chk("ram_word", dut.D_mem.RAM[32], 32'h8000007F);

        // Jumps.
        clear_prog();
        prog[0] = enc_j(8, 1);
        prog[1] = enc_i(1, 0, 0, 5, 7'h13);
        prog[2] = enc_i(3, 0, 0, 2, 7'h67);
        start_prog();
        run(1);
        lit("jal_link", 1, 32'd4);
        lit_pc("jal_pc", 32'd8);
        run(1);
        lit("jalr_link", 2, 32'd12);
        lit_pc("jalr_pc", 32'd2);
        run(1);
        lit("jal_from_pc2", 1, 32'd6);
        lit_pc("jal_pc2_target", 32'd10);
        lit("skipped_x5", 5, 32'd0);

        // Signed/unsigned branches, x0 write discard, wrap at last ROM word.
        clear_prog();
        prog[0]   = enc_i(5, 0, 0, 0, 7'h13);
        prog[1]   = enc_i(-1, 0, 0, 5, 7'h13);
        prog[2]   = enc_i(1, 0, 0, 6, 7'h13);
        prog[3]   = enc_b(8, 5, 6, 6);
        prog[4]   = enc_i(1, 0, 0, 10, 7'h13);
        prog[5]   = enc_b(8, 5, 6, 4);
        prog[6]   = enc_i(1, 0, 0, 11, 7'h13);
        prog[7]   = enc_b(8, 5, 6, 5);
        prog[8]   = enc_i(1, 0, 0, 12, 7'h13);
        prog[9]   = enc_b(8, 5, 6, 7);
        prog[10]  = enc_i(1, 0, 0, 13, 7'h13);
        prog[11]  = enc_b(8, 5, 5, 0);
        prog[12]  = enc_i(1, 0, 0, 14, 7'h13);
        prog[13]  = enc_b(8, 5, 5, 1);
        prog[14]  = enc_i(1, 0, 0, 15, 7'h13);
        prog[15]  = enc_j(960, 0);
        prog[255] = enc_j(8, 0);
        start_prog();
        run(1);
        lit("x0_write", 0, 32'd0);
        run(12);
        lit_pc("jump_to_last", 32'd1020);
        run(1);
        lit_pc("wrap_pc", 32'd4);
        lit("bltu_taken", 10, 32'd0);
        lit("blt_not_taken", 11, 32'd1);
        lit("bge_taken", 12, 32'd0);
        lit("bgeu_not_taken", 13, 32'd1);
        lit("beq_taken", 14, 32'd0);
        lit("bne_not_taken", 15, 32'd1);

        run(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
